gpr_file: RTL

Parametrised general-purpose register file with multiple read and write ports and a per-register scoreboard, for the siiCpu integer pipeline. It holds architectural register state. It forwards same-cycle writeback data to readers, and tracks which registers have an in-flight producer so decode can stall on RAW hazards. Register 0 is hardwired to zero.

---
 rtl/gpr_file_if.sv | 37 +++
 rtl/gpr_file.sv | 113 +++++++++++
 2 files changed

// File: rtl/gpr_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_file_if
//  Description : Bundle of read, write, issue and flush signals between the
//                integer pipeline (master) and the general-purpose register
//                file (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpr_file_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      we_;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                flush;

    modport master (
        output rd_addr, we_, wr_addr, wr_data, iss_valid, iss_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, we_, wr_addr, wr_data, iss_valid, iss_addr, flush,
        output rd_data, rd_busy
    );
endinterface
`default_nettype wire

// File: rtl/gpr_file.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_file
//  Description : Multi-port general-purpose register file with a per-register
//                busy scoreboard. Register 0 is hardwired to zero.
//                Optional macro GPR_BYPASS_EN forwards same-cycle writeback
//                data (and a cleared busy view) to the read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    gpr_file_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    // Entry 0 has no storage: it is a constant zero on every read path.
    logic [XLEN-1:0] r_regs [1:NREG-1];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // One storage word per architectural register; each entry resolves its own
    // write enable so the highest-numbered matching write port wins.
    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic            w_wen;
        logic [XLEN-1:0] w_wdata;

        // Pick the write port (if any) targeting this entry; later ports override.
        always_comb begin
            w_wen   = 1'b0;
            w_wdata = '0;
            for (int j = 0; j < NWR; j++) begin
                if (!bus.we_[j] && (bus.wr_addr[j*AW +: AW] == AW'(i))) begin
                    w_wen   = 1'b1;
                    w_wdata = bus.wr_data[j*XLEN +: XLEN];
                end
            end
        end

        // Store write data; reset clears the entry and discards any write.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_regs[i] <= '0;
            end else if (w_wen) begin
                r_regs[i] <= w_wdata;
            end
        end
    end

    // Next scoreboard state: retire on writeback, a new issue beats a retire,
    // flush beats everything, and entry 0 is never marked busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NWR; j++) begin
            if (!bus.we_[j]) begin
                w_busy_nxt[bus.wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (bus.iss_valid) begin
            w_busy_nxt[bus.iss_addr] = 1'b1;
        end
        if (bus.flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Combinational read ports.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = bus.rd_addr[k*AW +: AW];

        // Look up the stored word and busy bit; address 0 always reads idle zero.
        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (w_addr != '0) begin
                w_data = r_regs[w_addr];
                w_busy = r_busy[w_addr];
`ifdef GPR_BYPASS_EN
                // A writeback landing this cycle is forwarded and already retired.
                for (int j = 0; j < NWR; j++) begin
                    if (!bus.we_[j] && (bus.wr_addr[j*AW +: AW] == w_addr)) begin
                        w_data = bus.wr_data[j*XLEN +: XLEN];
                        w_busy = 1'b0;
                    end
                end
`endif
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] = w_data;
        assign bus.rd_busy[k]              = w_busy;
    end
endmodule
`default_nettype wire
